// File: rtl/sm_hex_display_scan.sv
// Time-multiplexed 7-segment scan driver: one lit digit per slot, a dark
// blanking gap between slots, and digit codes frozen once per frame.
module sm_hex_display_scan #(
   parameter int DIGITS         = 3,
   parameter int SHOW_CYCLES    = 50000,
   parameter int BLANK_CYCLES   = 5000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [7*DIGITS-1:0]   digits,
   input  logic [DIGITS-1:0]     dp,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame_start
);

   localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int IDX_W   = $clog2(DIGITS);
   localparam bit INV     = (SEG_ACTIVE_LOW != 0);

   localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [CNT_W-1:0]      r_cnt;
   logic [8*DIGITS-1:0]   r_snap;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic [DIGITS-1:0]     r_den;
   logic                  r_frame;

   state_t                w_state_nx;
   logic [IDX_W-1:0]      w_idx_nx;
   logic [CNT_W-1:0]      w_cnt_nx;
   logic                  w_capture;
   logic [8*DIGITS-1:0]   w_snap_in;
   logic [8*DIGITS-1:0]   w_snap_nx;
   logic                  w_lit;
   logic [7:0]            w_cur;
   logic [DIGITS-1:0]     w_den_nx;
   logic [6:0]            w_seg_nx;
   logic                  w_dp_nx;

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_cnt_nx   = r_cnt - CNT_W'(1);
      w_capture  = 1'b0;
      if (r_cnt == '0) begin
         case (r_state)
            ST_BLANK: begin
               w_state_nx = ST_SHOW;
               w_idx_nx   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
               w_cnt_nx   = SHOW_LOAD;
               w_capture  = (r_idx == LAST_IDX);
            end
            default: begin
               w_state_nx = ST_BLANK;
               w_cnt_nx   = BLANK_LOAD;
            end
         endcase
      end
   end

   // Each snapshot byte is {dp, g..a} so one slice feeds a whole digit.
   always_comb begin
      w_snap_in = '0;
      for (int k = 0; k < DIGITS; k++) begin
         w_snap_in[8*k +: 8] = {dp[k], digits[7*k +: 7]};
      end
   end

   // The fresh capture is forwarded so frame's first lit cycle already shows it.
   assign w_snap_nx = w_capture ? w_snap_in : r_snap;
   assign w_lit     = (w_state_nx == ST_SHOW);

   always_comb begin
      w_cur    = '0;
      w_den_nx = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (w_idx_nx == IDX_W'(k)) begin
            w_cur       = w_snap_nx[8*k +: 8];
            w_den_nx[k] = w_lit;
         end
      end
   end

   assign w_seg_nx = w_lit ? w_cur[6:0] : 7'h00;
   assign w_dp_nx  = w_lit & w_cur[7];

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         r_state <= ST_BLANK;
         r_idx   <= LAST_IDX;
         r_cnt   <= BLANK_LOAD;
         r_snap  <= '0;
         r_seg   <= {7{INV}};
         r_dp    <= INV;
         r_den   <= {DIGITS{INV}};
         r_frame <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_cnt   <= w_cnt_nx;
         r_snap  <= w_snap_nx;
         r_seg   <= w_seg_nx ^ {7{INV}};
         r_dp    <= w_dp_nx ^ INV;
         r_den   <= w_den_nx ^ {DIGITS{INV}};
         r_frame <= w_capture;
      end
   end

   assign seg_out     = r_seg;
   assign dp_out      = r_dp;
   assign digit_en    = r_den;
   assign frame_start = r_frame;

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Bench for sm_hex_display_scan: directed scenarios then random frames, with an
// active-high and an active-low instance checked against a frame-position model.
module tb_sm_hex_display_scan;

   localparam int D    = 3;
   localparam int S    = 4;
   localparam int B    = 2;
   localparam int SLOT = S + B;
   localparam int P    = D * SLOT;

   logic           clk = 1'b0;
   logic           rst;
   logic           enable;
   logic [7*D-1:0] digits;
   logic [D-1:0]   dp;

   logic [6:0]     seg_h, seg_l;
   logic           dp_h, dp_l;
   logic [D-1:0]   den_h, den_l;
   logic           fs_h, fs_l;

   sm_hex_display_scan #(.DIGITS(D), .SHOW_CYCLES(S), .BLANK_CYCLES(B), .SEG_ACTIVE_LOW(0)) u_dut_h (
      .clk(clk), .rst(rst), .enable(enable), .digits(digits), .dp(dp),
      .seg_out(seg_h), .dp_out(dp_h), .digit_en(den_h), .frame_start(fs_h));

   sm_hex_display_scan #(.DIGITS(D), .SHOW_CYCLES(S), .BLANK_CYCLES(B), .SEG_ACTIVE_LOW(1)) u_dut_l (
      .clk(clk), .rst(rst), .enable(enable), .digits(digits), .dp(dp),
      .seg_out(seg_l), .dp_out(dp_l), .digit_en(den_l), .frame_start(fs_l));

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   int           c      = 0;   // cycle number since the last restart, 1 = first dark cycle
   int           offrun = 0;
   logic [D-1:0] prev_den = '0;
   logic [6:0]   m_seg [D];
   logic         m_dp  [D];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (c=%0d)", tag, got, exp, c);
      end
   endtask

   task automatic check_cycle();
      int           pos, slot, off;
      bit           lit;
      logic [6:0]   es, es_l;
      logic         ed, ed_l, efs;
      logic [D-1:0] een, een_l;
      pos  = (c - 1) % P;
      slot = pos / SLOT;
      off  = pos % SLOT;
      lit  = (off >= B);
      een  = '0;
      if (lit) een[slot] = 1'b1;
      es   = lit ? m_seg[slot] : 7'h00;
      ed   = lit ? m_dp[slot] : 1'b0;
      efs  = lit && (slot == 0) && (off == B);
      es_l  = ~es;
      ed_l  = ~ed;
      een_l = ~een;
      chk("den_h", den_h, een);
      chk("seg_h", seg_h, es);
      chk("dp_h",  dp_h,  ed);
      chk("fs_h",  fs_h,  efs);
      chk("den_l", den_l, een_l);
      chk("seg_l", seg_l, es_l);
      chk("dp_l",  dp_l,  ed_l);
      chk("fs_l",  fs_l,  efs);
      checks++;
      assert ($onehot0(den_h)) else begin
         errors++;
         $error("FAIL onehot: observed %b expected at most one bit set", den_h);
      end
      if (den_h != '0 && den_h != prev_den) begin
         checks++;
         assert (prev_den == '0 && offrun >= B) else begin
            errors++;
            $error("FAIL gap: observed prev=%b offrun=%0d expected prev=0 offrun>=%0d", prev_den, offrun, B);
         end
      end
      if (den_h == '0) offrun++;
      else offrun = 0;
      prev_den = den_h;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst || !enable) begin
         c = 1;
         for (int k = 0; k < D; k++) begin
            m_seg[k] = 7'h00;
            m_dp[k]  = 1'b0;
         end
      end else begin
         c++;
         if ((c - 1) % P == B) begin
            for (int k = 0; k < D; k++) begin
               m_seg[k] = digits[7*k +: 7];
               m_dp[k]  = dp[k];
            end
         end
      end
      #1;
      check_cycle();
   endtask

   task automatic run_to(input int n);
      int guard;
      guard = 0;
      while (c != n && guard < 100) begin
         tick();
         guard++;
      end
      chk("run_to", c, n);
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b1;
      digits = {7'h4F, 7'h5B, 7'h06};
      dp     = 3'b010;
      tick();
      tick();
      rst = 1'b0;
      chk("s1_c1_den", den_h, 3'b000);
      chk("s5_blank_seg_l", seg_l, 7'h7F);
      chk("s5_blank_den_l", den_l, 3'b111);

      run_to(3);
      chk("s1_c3_fs", fs_h, 1);
      chk("s1_c3_den", den_h, 3'b001);
      chk("s1_c3_seg", seg_h, 7'h06);
      chk("s1_c3_dp", dp_h, 0);
      chk("s5_lit_seg_l", seg_l, 7'h79);
      chk("s5_lit_den_l", den_l, 3'b110);
      run_to(4);
      digits[6:0] = 7'h3F;
      run_to(6);
      chk("s2_c6_seg", seg_h, 7'h06);
      chk("s1_c6_fs", fs_h, 0);
      run_to(7);
      chk("s1_c7_den", den_h, 3'b000);
      run_to(9);
      chk("s1_c9_den", den_h, 3'b010);
      chk("s1_c9_seg", seg_h, 7'h5B);
      chk("s1_c9_dp", dp_h, 1);
      run_to(15);
      chk("s1_c15_den", den_h, 3'b100);
      chk("s1_c15_seg", seg_h, 7'h4F);
      run_to(20);
      chk("s1_c20_fs", fs_h, 0);
      run_to(21);
      chk("s1_c21_fs", fs_h, 1);
      chk("s2_c21_seg", seg_h, 7'h3F);

      run_to(28);
      chk("s3_lit_before_drop", den_h, 3'b010);
      enable = 1'b0;
      tick();
      chk("s3_off_den", den_h, 3'b000);
      chk("s3_off_seg", seg_h, 7'h00);
      repeat (3) tick();
      enable = 1'b1;
      run_to(2);
      chk("s3_dark_den", den_h, 3'b000);
      run_to(3);
      chk("s3_fs", fs_h, 1);
      chk("s3_den", den_h, 3'b001);
      chk("s3_seg", seg_h, 7'h3F);

      run_to(16);
      chk("s4_idx2_den", den_h, 3'b100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("s4_off_den", den_h, 3'b000);
      chk("s4_off_fs", fs_h, 0);
      run_to(3);
      chk("s4_fs", fs_h, 1);
      chk("s4_den", den_h, 3'b001);
      run_to(21);
      chk("s4_fs2", fs_h, 1);

      repeat (100 * P) begin
         digits = 21'($urandom);
         dp     = 3'($urandom);
         enable = ($urandom_range(0, 99) != 0);
         rst    = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst    = 1'b0;
      enable = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
